// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch stage: opcode nibbles that
// need operand bytes, fetch FSM states and the instruction length type.
package ifetch_pkg;

    // Opcode nibbles (IM_DATA[7:4]) that carry operand bytes
    localparam logic [3:0] OP_LOADACI = 4'h0;
    localparam logic [3:0] OP_JPNZ    = 4'h5;
    localparam logic [3:0] OP_ADDI    = 4'h8;
    localparam logic [3:0] OP_SUBI    = 4'h9;

    // Instruction length in bytes, 1..3
    typedef logic [1:0] instr_len_t;

    localparam instr_len_t LEN_1 = 2'd1;
    localparam instr_len_t LEN_2 = 2'd2;
    localparam instr_len_t LEN_3 = 2'd3;

    // Fetch FSM: opcode byte, first operand byte, second operand byte, present
    typedef enum logic [1:0] {
        F_OP = 2'd0,
        F_B1 = 2'd1,
        F_B2 = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    // Length of an instruction given its opcode nibble
    function automatic instr_len_t decode_len(input logic [3:0] nibble);
        instr_len_t len;
        case (nibble)
            OP_LOADACI, OP_JPNZ: len = LEN_3;
            OP_ADDI, OP_SUBI:    len = LEN_2;
            default:             len = LEN_1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/ifetch_len_decode.sv
// Combinational instruction length decoder driven by the opcode nibble.
module ifetch_len_decode
    import ifetch_pkg::*;
(
    input  logic [3:0] opcode_nibble,
    output instr_len_t len
);

    // Map the opcode nibble straight to its byte count
    always_comb begin
        len = decode_len(opcode_nibble);
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: walks the byte-wide instruction memory, assembles 1..3 byte
// instructions and presents each one to the control unit via valid/ready.
// Redirects from the branch logic override any fetch in progress.
module instr_fetch_unit
    import ifetch_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] START_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [ADDR_W-1:0] im_addr,
    input  logic [7:0]        im_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [7:0]        instr_op,
    output logic [15:0]       instr_imm,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              br_take,
    input  logic [ADDR_W-1:0] br_target
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_inc;
    instr_len_t        len_q, len_d;
    instr_len_t        cur_len;
    logic [7:0]        op_q, op_d;
    logic [15:0]       imm_q, imm_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic              valid_q, valid_d;

    ifetch_len_decode u_len_decode (
        .opcode_nibble (im_data[7:4]),
        .len           (cur_len)
    );

    assign pc_inc      = pc_q + ADDR_W'(1);
    assign im_addr     = pc_q;
    assign instr_valid = valid_q;
    assign instr_op    = op_q;
    assign instr_imm   = imm_q;
    assign instr_pc    = ipc_q;

    // Fetch FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= F_OP;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next datapath values; a redirect overrides fetch progress
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        op_d    = op_q;
        imm_d   = imm_q;
        ipc_d   = ipc_q;

        if (br_take) begin
            pc_d    = br_target;
            state_d = F_OP;
        end else begin
            case (state_q)
                F_OP: begin
                    if (en) begin
                        op_d    = im_data;
                        ipc_d   = pc_q;
                        imm_d   = '0;
                        pc_d    = pc_inc;
                        len_d   = cur_len;
                        state_d = (cur_len == LEN_1) ? HOLD : F_B1;
                    end
                end
                F_B1: begin
                    if (en) begin
                        pc_d = pc_inc;
                        if (len_q == LEN_2) begin
                            imm_d   = {8'h00, im_data};
                            state_d = HOLD;
                        end else begin
                            imm_d[15:8] = im_data;
                            state_d     = F_B2;
                        end
                    end
                end
                F_B2: begin
                    if (en) begin
                        imm_d[7:0] = im_data;
                        pc_d       = pc_inc;
                        state_d    = HOLD;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        state_d = F_OP;
                    end
                end
                default: begin
                    state_d = F_OP;
                end
            endcase
        end

        valid_d = (state_d == HOLD);
    end

    // PC, partial instruction and presented instruction registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= START_PC;
            len_q   <= LEN_1;
            op_q    <= '0;
            imm_q   <= '0;
            ipc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            len_q   <= len_d;
            op_q    <= op_d;
            imm_q   <= imm_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a random
// phase, all checked against a transaction-level model of the instruction stream.
module tb_instr_fetch_unit;

    localparam logic [15:0] START_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] im_addr;
    logic [7:0]  im_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  instr_op;
    logic [15:0] instr_imm;
    logic [15:0] instr_pc;
    logic        br_take;
    logic [15:0] br_target;

    logic [7:0]  mem [0:65535];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_count = 0;
    int hs_cycle = 0;
    int prev_hs_cycle = 0;

    logic [15:0] exp_pc;
    logic [7:0]  last_op;
    logic [15:0] last_imm;
    logic [15:0] last_pc;

    logic        held_ok;
    logic [7:0]  held_op;
    logic [15:0] held_imm;
    logic [15:0] held_pc;

    instr_fetch_unit #(.ADDR_W(16), .START_PC(START_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .im_addr     (im_addr),
        .im_data     (im_data),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_imm   (instr_imm),
        .instr_pc    (instr_pc),
        .br_take     (br_take),
        .br_target   (br_target)
    );

    // Combinational instruction memory
    assign im_data = mem[im_addr];

    always #5 clk = ~clk;

    function automatic int refLen(input logic [7:0] op);
        case (op[7:4])
            4'h0, 4'h5: return 3;
            4'h8, 4'h9: return 2;
            default:    return 1;
        endcase
    endfunction

    function automatic logic [15:0] refImm(input logic [15:0] pc);
        logic [15:0] a1;
        logic [15:0] a2;
        int          l;
        a1 = pc + 16'd1;
        a2 = pc + 16'd2;
        l  = refLen(mem[pc]);
        if (l == 3) return {mem[a1], mem[a2]};
        if (l == 2) return {8'h00, mem[a1]};
        return 16'h0000;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Evaluated mid-cycle: checks whatever the DUT presents this cycle
    task automatic modelCycle();
        logic [15:0] nxt;
        if (instr_valid) begin
            if (held_ok) begin
                checkOutput("hold_op", {24'h0, instr_op}, {24'h0, held_op});
                checkOutput("hold_imm", {16'h0, instr_imm}, {16'h0, held_imm});
                checkOutput("hold_pc", {16'h0, instr_pc}, {16'h0, held_pc});
            end
            nxt = exp_pc + 16'(refLen(mem[exp_pc]));
            checkOutput("hold_addr", {16'h0, im_addr}, {16'h0, nxt});
            if (instr_ready) begin
                checkOutput("hs_pc", {16'h0, instr_pc}, {16'h0, exp_pc});
                checkOutput("hs_op", {24'h0, instr_op}, {24'h0, mem[exp_pc]});
                checkOutput("hs_imm", {16'h0, instr_imm}, {16'h0, refImm(exp_pc)});
                last_op       = instr_op;
                last_imm      = instr_imm;
                last_pc       = instr_pc;
                hs_count++;
                prev_hs_cycle = hs_cycle;
                hs_cycle      = cyc;
                exp_pc        = nxt;
            end
        end
        held_ok  = instr_valid && !instr_ready && !br_take;
        held_op  = instr_op;
        held_imm = instr_imm;
        held_pc  = instr_pc;
        if (br_take) exp_pc = br_target;
    endtask

    task automatic applyStimulus(input logic e, input logic r, input logic b, input logic [15:0] t);
        en          = e;
        instr_ready = r;
        br_take     = b;
        br_target   = t;
    endtask

    task automatic runCycle();
        @(negedge clk);
        modelCycle();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", {31'h0, instr_valid}, 32'h0);
        checkOutput("rst_addr", {16'h0, im_addr}, {16'h0, START_PC});
        checkOutput("rst_op", {24'h0, instr_op}, 32'h0);
        checkOutput("rst_imm", {16'h0, instr_imm}, 32'h0);
        checkOutput("rst_ipc", {16'h0, instr_pc}, 32'h0);
        rst_n   = 1'b1;
        exp_pc  = START_PC;
        held_ok = 1'b0;
    endtask

    task automatic waitHandshake(input string tag, input int budget);
        int start;
        start = hs_count;
        for (int i = 0; i < budget; i++) begin
            if (hs_count != start) break;
            runCycle();
        end
        checkOutput(tag, {31'h0, hs_count != start}, 32'h1);
    endtask

    initial begin
        int c0;
        int start_hs;
        logic [15:0] frozen;
        int r;

        held_ok = 1'b0;
        exp_pc  = START_PC;
        rst_n   = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

        // Scenario 1: LOADACI then 1-byte op, latency and throughput
        mem[0] = 8'h0F; mem[1] = 8'h00; mem[2] = 8'h05; mem[3] = 8'h41;
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        c0 = cyc;
        waitHandshake("t1_hs_a", 10);
        checkOutput("t1_op_a", {24'h0, last_op}, 32'h0F);
        checkOutput("t1_imm_a", {16'h0, last_imm}, 32'h0005);
        checkOutput("t1_pc_a", {16'h0, last_pc}, 32'h0000);
        checkOutput("t1_latency", hs_cycle - c0, 3);
        waitHandshake("t1_hs_b", 10);
        checkOutput("t1_op_b", {24'h0, last_op}, 32'h41);
        checkOutput("t1_imm_b", {16'h0, last_imm}, 32'h0000);
        checkOutput("t1_pc_b", {16'h0, last_pc}, 32'h0003);
        checkOutput("t1_gap", hs_cycle - prev_hs_cycle, 2);

        // Scenario 2: two 2-byte instructions
        mem[0] = 8'h8F; mem[1] = 8'h03; mem[2] = 8'h9F; mem[3] = 8'h02;
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        waitHandshake("t2_hs_a", 10);
        checkOutput("t2_op_a", {24'h0, last_op}, 32'h8F);
        checkOutput("t2_imm_a", {16'h0, last_imm}, 32'h0003);
        waitHandshake("t2_hs_b", 10);
        checkOutput("t2_op_b", {24'h0, last_op}, 32'h9F);
        checkOutput("t2_imm_b", {16'h0, last_imm}, 32'h0002);
        checkOutput("t2_pc_b", {16'h0, last_pc}, 32'h0002);
        checkOutput("t2_gap", hs_cycle - prev_hs_cycle, 3);

        // Scenario 3: READY withheld in HOLD
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            if (instr_valid) break;
            runCycle();
        end
        checkOutput("t3_valid", {31'h0, instr_valid}, 32'h1);
        frozen = im_addr;
        repeat (5) runCycle();
        checkOutput("t3_addr_frozen", {16'h0, im_addr}, {16'h0, frozen});
        checkOutput("t3_op_held", {24'h0, instr_op}, 32'h8F);
        checkOutput("t3_valid_held", {31'h0, instr_valid}, 32'h1);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        waitHandshake("t3_hs_a", 4);
        waitHandshake("t3_hs_b", 10);
        checkOutput("t3_next_pc", {16'h0, last_pc}, 32'h0002);

        // Scenario 4: redirect during F_B1 of LOADACI
        mem[0] = 8'h00; mem[1] = 8'hAA; mem[2] = 8'hBB; mem[16'h0102] = 8'h41;
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        runCycle();
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h0102);
        runCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        start_hs = hs_count;
        waitHandshake("t4_hs", 10);
        checkOutput("t4_first_after_br", hs_count - start_hs, 1);
        checkOutput("t4_pc", {16'h0, last_pc}, 32'h0102);
        checkOutput("t4_op", {24'h0, last_op}, 32'h41);

        // Scenario 5: 3-byte instruction wrapping at FFFF
        mem[16'hFFFF] = 8'h5F; mem[0] = 8'h01; mem[1] = 8'h02;
        mem[2] = 8'h83; mem[3] = 8'h44;
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b1, 16'hFFFF);
        runCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        waitHandshake("t5_hs_a", 10);
        checkOutput("t5_op", {24'h0, last_op}, 32'h5F);
        checkOutput("t5_imm", {16'h0, last_imm}, 32'h0102);
        checkOutput("t5_pc", {16'h0, last_pc}, 32'hFFFF);
        waitHandshake("t5_hs_b", 10);
        checkOutput("t5_next_pc", {16'h0, last_pc}, 32'h0002);
        checkOutput("t5_next_imm", {16'h0, last_imm}, 32'h0044);

        // Scenario 6: EN stall mid-instruction, then async reset in F_B2
        mem[0] = 8'h0F; mem[1] = 8'h12; mem[2] = 8'h34; mem[3] = 8'h41;
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        runCycle();
        runCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        repeat (3) runCycle();
        checkOutput("t6_stall_addr", {16'h0, im_addr}, 32'h0002);
        checkOutput("t6_stall_valid", {31'h0, instr_valid}, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_async_valid", {31'h0, instr_valid}, 32'h0);
        checkOutput("t6_async_addr", {16'h0, im_addr}, {16'h0, START_PC});
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        exp_pc  = START_PC;
        held_ok = 1'b0;
        waitHandshake("t6_hs", 10);
        checkOutput("t6_op", {24'h0, last_op}, 32'h0F);
        checkOutput("t6_imm", {16'h0, last_imm}, 32'h1234);
        checkOutput("t6_pc", {16'h0, last_pc}, 32'h0000);

        // Random phase: random enable, ready and redirects
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        doReset();
        start_hs = hs_count;
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 2);
            applyStimulus($urandom_range(0, 3) != 0,
                          $urandom_range(0, 2) != 0,
                          $urandom_range(0, 24) == 0,
                          (r == 0) ? 16'hFFFE : (r == 1) ? 16'hFFFF : 16'($urandom));
            runCycle();
        end
        checkOutput("rand_progress", {31'h0, (hs_count - start_hs) > 200}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
